// File: rtl/audio_pdm_sink_pkg.sv
// Shared audio constants: the sample format and sample rate that producers and
// this sink must agree on.
package audio_pdm_sink_pkg;
    localparam int AUDIO_BITDEPTH  = 12;
    localparam int AUDIO_DIV_LOG2  = 8;
    localparam int AUDIO_FIFO_LOG2 = 2;
    localparam int AUDIO_MIDSCALE  = 1 << (AUDIO_BITDEPTH - 1);

    function automatic int audio_midscale(input int bitdepth);
        return 1 << (bitdepth - 1);
    endfunction
endpackage

// File: rtl/audio_pdm_sink_if.sv
// Sample stream handshake from a producer (master) into the sink (slave).
interface audio_pdm_sink_if #(
    parameter int BITDEPTH = audio_pdm_sink_pkg::AUDIO_BITDEPTH
);
    logic [BITDEPTH-1:0] in_sample;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_sample, output in_valid, input in_ready);
    modport slave  (input in_sample, input in_valid, output in_ready);
endinterface

// File: rtl/audio_pdm_sink_fifo.sv
// Small synchronous sample FIFO; ready is a register so producers never see a
// combinational path from the sink's pop logic.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int LOG2  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [LOG2:0]    o_level,
    output logic             o_ready,
    output logic             o_empty
);
    localparam int          DEPTH = 1 << LOG2;
    localparam logic [LOG2:0] FULL = (LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LOG2-1:0]  r_wr, r_rd;
    logic [LOG2:0]    r_level;
    logic             r_ready;
    logic             w_push, w_pop;
    logic [LOG2:0]    w_level_nx;

    // Pop sees only the registered level, so a same-cycle push into an empty
    // FIFO is not forwarded.
    assign w_push = i_push & r_ready;
    assign w_pop  = i_pop & (r_level != '0);

    always_comb begin
        w_level_nx = r_level;
        if (w_push && !w_pop)      w_level_nx = r_level + 1'b1;
        else if (!w_push && w_pop) w_level_nx = r_level - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_level <= w_level_nx;
            r_ready <= (w_level_nx != FULL);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_level = r_level;
    assign o_ready = r_ready;
    assign o_empty = (r_level == '0);
endmodule

// File: rtl/audio_pdm_sink.sv
// Audio sink: sample-rate divider, sample FIFO with underrun tracking, and a
// second-order sigma-delta modulator driving the 1-bit audio pin.
module audio_pdm_sink
    import audio_pdm_sink_pkg::*;
#(
    parameter int BITDEPTH  = AUDIO_BITDEPTH,
    parameter int DIV_LOG2  = AUDIO_DIV_LOG2,
    parameter int FIFO_LOG2 = AUDIO_FIFO_LOG2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    audio_pdm_sink_if.slave      s_if,
    output logic                 o_sample_clock,
    output logic                 o_pdm_out,
    output logic                 o_underrun,
    output logic [7:0]           o_underrun_count,
    output logic [FIFO_LOG2:0]   o_level
);
    localparam int W   = BITDEPTH + 4;
    localparam int MID = audio_midscale(BITDEPTH);
    localparam logic signed [W+1:0] MIDS = (W + 2)'(MID);
    localparam logic signed [W+1:0] SMAX = (W + 2)'((2 ** (W - 1)) - 1);
    localparam logic signed [W+1:0] SMIN = -SMAX;

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        if (v > SMAX)      return SMAX[W-1:0];
        else if (v < SMIN) return SMIN[W-1:0];
        else               return v[W-1:0];
    endfunction

    logic [DIV_LOG2-1:0] r_div;
    logic                r_sclk;
    logic                w_tick;
    logic [BITDEPTH-1:0] w_head;
    logic                w_empty;
    logic [BITDEPTH-1:0] r_cur;
    logic [7:0]          r_ucnt;
    logic signed [W-1:0] r_i1, r_i2;
    logic                r_pdm;
    logic signed [W+1:0] w_x, w_f;
    logic signed [W-1:0] w_i1_nx, w_i2_nx;

    assign w_tick = &r_div;

    sample_fifo #(.WIDTH(BITDEPTH), .LOG2(FIFO_LOG2)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst),
        .i_push  (s_if.in_valid),
        .i_din   (s_if.in_sample),
        .i_pop   (w_tick),
        .o_head  (w_head),
        .o_level (o_level),
        .o_ready (s_if.in_ready),
        .o_empty (w_empty)
    );

    // Integrators carry two guard bits before clamping; i2 uses the old i1.
    always_comb begin
        w_x     = $signed({{(W + 2 - BITDEPTH){1'b0}}, r_cur}) - MIDS;
        w_f     = r_pdm ? MIDS : -MIDS;
        w_i1_nx = sat($signed({{2{r_i1[W-1]}}, r_i1}) + w_x - w_f);
        w_i2_nx = sat($signed({{2{r_i2[W-1]}}, r_i2})
                    + $signed({{2{r_i1[W-1]}}, r_i1}) - w_f);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_cur  <= BITDEPTH'(MID);
            r_ucnt <= '0;
            r_i1   <= '0;
            r_i2   <= '0;
            r_pdm  <= 1'b0;
        end else begin
            r_div  <= r_div + 1'b1;
            r_sclk <= r_div[DIV_LOG2-1];
            if (w_tick) begin
                if (!w_empty)             r_cur  <= w_head;
                else if (r_ucnt != 8'hFF) r_ucnt <= r_ucnt + 1'b1;
            end
            r_i1  <= w_i1_nx;
            r_i2  <= w_i2_nx;
            r_pdm <= ~w_i2_nx[W-1];
        end
    end

    assign o_underrun       = w_tick & w_empty & i_rst;
    assign o_underrun_count = r_ucnt;
    assign o_sample_clock   = r_sclk;
    assign o_pdm_out        = r_pdm;
endmodule

// File: doc/audio_pdm_sink.md
# audio_pdm_sink

Consumer end of the audio sample path: accepts unsigned samples from the oscillator/mixer over a valid/ready handshake, buffers them in a small FIFO, and releases one per sample period. It also generates the `sample_clock` that paces the producers, and converts the current sample to a 1-bit pulse-density stream with a second-order sigma-delta modulator for the badge's audio pin.

## Interface
- `BITDEPTH`, 12: sample width (unsigned, midscale = 2^(BITDEPTH-1)).
- `DIV_LOG2`, 8: sample period = 2^DIV_LOG2 clocks (8 MHz / 256 = 31.25 kHz).
- `FIFO_LOG2`, 2: FIFO depth = 2^FIFO_LOG2 entries.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `in_sample`  in  BITDEPTH  unsigned sample from the producer.
- `in_valid`  in  1  `in_sample` is valid.
- `in_ready`  out  1  FIFO can accept; a transfer occurs when valid & ready.
- `sample_clock`  out  1  square wave, period 2^DIV_LOG2 clocks, for producers.
- `pdm_out`  out  1  pulse-density audio bitstream.
- `underrun`  out  1  one-cycle pulse: sample tick found the FIFO empty.
- `underrun_count`  out  8  saturating count of underruns.
- `level`  out  FIFO_LOG2+1  FIFO occupancy, 0..2^FIFO_LOG2.

## Operation
- Divider: free-running DIV_LOG2-bit counter `div`. `tick` = (`div` == all-ones). `sample_clock` = registered `div` MSB.
- FIFO: `in_ready` = (`level` != 2^FIFO_LOG2), driven from registers. Push on valid & ready. Pop on tick & `level` != 0. Simultaneous push and pop leaves `level` unchanged. Pointers wrap modulo depth. There is no bypass: a push into an empty FIFO on a tick cycle is not popped on that tick.
- Tick with FIFO non-empty: `cur` <= head entry.
- Tick with FIFO empty: `cur` holds its value, `underrun` pulses, and `underrun_count` increments, saturating at 255.
- Modulator, updated every clk. Widths are signed with W = BITDEPTH+4.
  - x = `cur` − 2^(BITDEPTH-1).
  - f = +2^(BITDEPTH-1) if `pdm_out` else −2^(BITDEPTH-1).
  - i1 <= sat(i1 + x − f); i2 <= sat(i2 + i1 − f), where i2 uses the old i1.
  - `pdm_out` <= (new i2 >= 0).
  - sat clamps to ±(2^(W-1) − 1).

## Timing
- Reset (rst low at an edge) sets:
  - `div` = 0, FIFO empty, `level` = 0.
  - `cur` = 2^(BITDEPTH-1), i1 = i2 = 0.
  - `pdm_out` = 0, `sample_clock` = 0, `underrun` = 0, `underrun_count` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- Reset asserted mid-operation discards FIFO contents and the modulator state. A handshake in the reset cycle is ignored.
- First tick is on cycle 255 after reset release (cycle 0 = first cycle with rst high). Subsequent ticks occur every 256 cycles.
- Timing of `cur` and modulator update:
  - `cur` updates at the end of the tick cycle.
  - The modulator first uses the new `cur` on the following cycle.
  - `pdm_out` reflects that value one clock later.
- `sample_clock` rises 129 cycles after reset release (`div` MSB set at `div` = 128, registered).
- `level` and `in_ready` update one clock after the push or pop edge.

## Structure
- Shared audio package holds:
  - the default BITDEPTH;
  - the sample-period constant (DIV_LOG2 = 8);
  - the midscale constant, so the oscillator and this sink agree on rate and format.
- One natural sub-module is `sample_fifo`: a parameterized synchronous FIFO with push, pop, `level` and full/empty flags. Divider, underrun logic and modulator stay in the top.

## Test plan
- Reset: hold rst low 4 cycles, then release. Required: `pdm_out` = 0, `level` = 0, `in_ready` = 1, `underrun_count` = 0; first `underrun` pulse at cycle 255.
- Fill: push 0x100, 0x200, 0x300, 0x400 back-to-back from cycle 0. Required:
  - `in_ready` = 0 once `level` = 4; a fifth push is held off.
  - Ticks at 255, 511, 767 and 1023 pop the samples in order.
  - `level` = 3 after the first tick.
- Simultaneous push/pop: with FIFO full, assert valid on cycle 255. Required:
  - No transfer (ready low), `level` goes 4→3.
  - At `level` = 1, a push on a tick cycle keeps `level` = 1.
- Underrun: no pushes for 3 periods. Required: 3 single-cycle `underrun` pulses, `underrun_count` = 3, `cur` stays at midscale; after 300 empty ticks, `underrun_count` = 255.
- Density: feed constant 0x800, then constant 0xC00. Required, after 1024 settling cycles, ones in any 256-cycle window:
  - 128 ± 2 for 0x800;
  - 192 ± 4 for 0xC00.
- Mid-operation reset: assert rst for 1 cycle while `level` = 2. Required: `level` = 0, `pdm_out` = 0, `cur` = 0x800 the next cycle, and `div` restarts with the next tick at cycle 255.
